// File: rtl/lockout_timer.sv
// lockout_timer: times an escalating lockout for each new sleep request from
// the Controller and answers with a one-cycle end_sleep pulse on expiry.
// Lockout length is BASE_SECS << lock_level seconds; a correct_password pulse
// drops the escalation level back to zero.
module lockout_timer #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned BASE_SECS = 5,
  parameter int unsigned MAX_LEVEL = 3
) (
  input  logic       clk,
  input  logic       system_reset,
  input  logic       sleep,
  input  logic       correct_password,
  output logic       end_sleep,
  output logic       sleeping,
  output logic [7:0] secs_left,
  output logic [1:0] lock_level
);

  localparam int unsigned   PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [1:0]    LVL_MAX  = 2'(MAX_LEVEL);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          sleep_d;
  logic          rise;
  logic          tick;
  logic [7:0]    load_secs;

  assign rise = sleep & ~sleep_d;
  assign tick = (prescaler == PRE_LAST);

  // Lockout length for the current escalation level
  always_comb begin
    load_secs = 8'(BASE_SECS << lock_level);
  end

  // Delayed copy of sleep for rising-edge detection
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      sleep_d <= 1'b0;
    end else begin
      sleep_d <= sleep;
    end
  end

  // Lockout state machine with registered outputs
  always_ff @(posedge clk or negedge system_reset) begin
    if (!system_reset) begin
      state      <= IDLE;
      prescaler  <= '0;
      end_sleep  <= 1'b0;
      sleeping   <= 1'b0;
      secs_left  <= '0;
      lock_level <= '0;
    end else begin
      end_sleep <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            secs_left <= load_secs;
            prescaler <= '0;
            sleeping  <= 1'b1;
            state     <= COUNT;
          end
        end
        COUNT: begin
          // Abort outranks the second tick
          if (!sleep) begin
            secs_left <= '0;
            sleeping  <= 1'b0;
            prescaler <= '0;
            state     <= IDLE;
          end else if (tick) begin
            prescaler <= '0;
            if (secs_left > 8'd1) begin
              secs_left <= secs_left - 8'd1;
            end else begin
              secs_left <= '0;
              end_sleep <= 1'b1;
              sleeping  <= 1'b0;
              if (lock_level < LVL_MAX) begin
                lock_level <= lock_level + 2'd1;
              end
              state <= DONE;
            end
          end else begin
            prescaler <= prescaler + 1'b1;
          end
        end
        DONE: begin
          if (!sleep) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
      // Placed last so a clear coinciding with expiry overrides the escalation
      if (correct_password) begin
        lock_level <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lockout_timer.sv
// Self-checking bench for lockout_timer with a time-based reference model.
module tb_lockout_timer;

  localparam int unsigned CLK_HZ    = 10;
  localparam int unsigned BASE_SECS = 2;
  localparam int unsigned MAX_LEVEL = 2;

  logic       clk = 1'b0;
  logic       system_reset;
  logic       sleep;
  logic       correct_password;
  logic       end_sleep;
  logic       sleeping;
  logic [7:0] secs_left;
  logic [1:0] lock_level;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: a lockout is a start time plus a length; remaining
  // seconds follow from elapsed cycles by division.
  bit          m_running;
  bit          m_end;
  bit          m_prev;
  int unsigned m_len;
  int unsigned m_elapsed;
  int unsigned m_level;

  lockout_timer #(
    .CLK_HZ   (CLK_HZ),
    .BASE_SECS(BASE_SECS),
    .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .clk             (clk),
    .system_reset    (system_reset),
    .sleep           (sleep),
    .correct_password(correct_password),
    .end_sleep       (end_sleep),
    .sleeping        (sleeping),
    .secs_left       (secs_left),
    .lock_level      (lock_level)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_running = 0;
    m_end     = 0;
    m_prev    = 0;
    m_len     = 0;
    m_elapsed = 0;
    m_level   = 0;
  endfunction

  function automatic void model_edge();
    m_end = 0;
    if (m_running) begin
      if (!sleep) begin
        m_running = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == m_len * CLK_HZ) begin
          m_running = 0;
          m_end     = 1;
          if (m_level < MAX_LEVEL) m_level++;
        end
      end
    end else if (sleep && !m_prev) begin
      m_running = 1;
      m_len     = BASE_SECS << m_level;
      m_elapsed = 0;
    end
    if (correct_password) m_level = 0;
    m_prev = sleep;
  endfunction

  function automatic logic [11:0] exp_word();
    int unsigned s;
    s = m_running ? (m_len - m_elapsed / CLK_HZ) : 0;
    return {m_end, m_running, s[7:0], m_level[1:0]};
  endfunction

  function automatic logic [11:0] dut_word();
    return {end_sleep, sleeping, secs_left, lock_level};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!system_reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    system_reset = 0;
    for (int i = 0; i < 4; i++) begin
      sleep            = 1'($urandom);
      correct_password = 1'($urandom);
      step();
      n_checks++;
      if (dut_word() !== 12'h000)
        $display("FAIL reset_hold cyc %0d: got %h expected %h", i, dut_word(), 12'h000);
      else n_pass++;
    end
    sleep            = 0;
    correct_password = 0;
    system_reset     = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (dut_word() !== 12'h000)
        $display("FAIL reset_release cyc %0d: got %h expected %h", i, dut_word(), 12'h000);
      else n_pass++;
    end
  endtask

  task automatic test_first_lockout();
    sleep = 1;
    for (int c = 1; c <= 21; c++) begin
      step();
      n_checks++;
      if (dut_word() !== exp_word())
        $display("FAIL first_model T+%0d: got %h expected %h", c, dut_word(), exp_word());
      else n_pass++;
      if (c == 1) begin
        n_checks++;
        if (sleeping !== 1'b1 || secs_left !== 8'd2)
          $display("FAIL first_load: got sleeping=%b secs=%0d expected sleeping=1 secs=2", sleeping, secs_left);
        else n_pass++;
      end
      if (c == 11) begin
        n_checks++;
        if (secs_left !== 8'd1)
          $display("FAIL first_tick: got secs=%0d expected 1", secs_left);
        else n_pass++;
      end
      if (c == 21) begin
        n_checks++;
        if (end_sleep !== 1'b1 || secs_left !== 8'd0 || sleeping !== 1'b0 || lock_level !== 2'd1)
          $display("FAIL first_expire: got end=%b secs=%0d sleeping=%b lvl=%0d expected 1 0 0 1",
                   end_sleep, secs_left, sleeping, lock_level);
        else n_pass++;
      end
    end
    for (int c = 0; c < 50; c++) begin
      step();
      n_checks++;
      if (end_sleep !== 1'b0 || dut_word() !== exp_word())
        $display("FAIL first_hold cyc %0d: got %h expected %h", c, dut_word(), exp_word());
      else n_pass++;
    end
  endtask

  task automatic test_escalation();
    int unsigned exp_load [3] = '{4, 8, 8};
    bit ended;
    int end_c;
    for (int k = 0; k < 3; k++) begin
      sleep = 0;
      repeat (3) step();
      sleep = 1;
      ended = 0;
      end_c = 0;
      for (int c = 1; c <= 200 && !ended; c++) begin
        step();
        n_checks++;
        if (dut_word() !== exp_word())
          $display("FAIL esc_model k%0d T+%0d: got %h expected %h", k, c, dut_word(), exp_word());
        else n_pass++;
        if (c == 1) begin
          n_checks++;
          if (secs_left !== exp_load[k][7:0])
            $display("FAIL esc_load k%0d: got %0d expected %0d", k, secs_left, exp_load[k]);
          else n_pass++;
        end
        if (end_sleep === 1'b1) begin
          ended = 1;
          end_c = c;
        end
      end
      n_checks++;
      if (!ended || end_c != int'(exp_load[k] * CLK_HZ + 1) || lock_level !== 2'd2)
        $display("FAIL esc_end k%0d: got ended=%0d at T+%0d lvl=%0d expected T+%0d lvl=2",
                 k, ended, end_c, lock_level, exp_load[k] * CLK_HZ + 1);
      else n_pass++;
    end
  endtask

  task automatic test_clear();
    sleep = 0;
    repeat (2) step();
    correct_password = 1;
    step();
    correct_password = 0;
    n_checks++;
    if (lock_level !== 2'd0 || dut_word() !== exp_word())
      $display("FAIL clear_level: got lvl=%0d expected 0", lock_level);
    else n_pass++;
    sleep = 1;
    step();
    n_checks++;
    if (secs_left !== 8'd2 || sleeping !== 1'b1)
      $display("FAIL clear_reload: got secs=%0d sleeping=%b expected 2 1", secs_left, sleeping);
    else n_pass++;
    sleep = 0;
    step();
  endtask

  task automatic test_abort();
    bit ended;
    int end_c;
    sleep = 1;
    for (int c = 1; c <= 15; c++) step();
    sleep = 0;
    step();
    n_checks++;
    if (sleeping !== 1'b0 || secs_left !== 8'd0 || end_sleep !== 1'b0 || lock_level !== 2'd0)
      $display("FAIL abort_state: got %h expected %h", dut_word(), 12'h000);
    else n_pass++;
    for (int c = 0; c < 30; c++) begin
      step();
      n_checks++;
      if (end_sleep !== 1'b0 || dut_word() !== exp_word())
        $display("FAIL abort_quiet cyc %0d: got %h expected %h", c, dut_word(), exp_word());
      else n_pass++;
    end
    sleep = 1;
    ended = 0;
    end_c = 0;
    for (int c = 1; c <= 100 && !ended; c++) begin
      step();
      if (c == 1) begin
        n_checks++;
        if (secs_left !== 8'd2)
          $display("FAIL abort_restart: got secs=%0d expected 2", secs_left);
        else n_pass++;
      end
      if (end_sleep === 1'b1) begin
        ended = 1;
        end_c = c;
      end
    end
    n_checks++;
    if (!ended || end_c != 21 || lock_level !== 2'd1)
      $display("FAIL abort_rerun: got ended=%0d at T+%0d lvl=%0d expected T+21 lvl=1", ended, end_c, lock_level);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) sleep = ~sleep;
      correct_password = ($urandom_range(0, 299) == 0);
      step();
      n_checks++;
      if (dut_word() !== exp_word())
        $display("FAIL random cyc %0d: got %h expected %h", c, dut_word(), exp_word());
      else n_pass++;
    end
    correct_password = 0;
  endtask

  task automatic test_async_reset();
    sleep = 0;
    repeat (2) step();
    sleep = 1;
    for (int c = 1; c <= 7; c++) step();
    #3;
    system_reset = 0;
    #1;
    model_reset();
    n_checks++;
    if (dut_word() !== 12'h000)
      $display("FAIL async_reset: got %h expected %h", dut_word(), 12'h000);
    else n_pass++;
    #2;
    sleep        = 0;
    system_reset = 1;
    step();
    sleep = 1;
    step();
    n_checks++;
    if (secs_left !== 8'd2 || sleeping !== 1'b1 || lock_level !== 2'd0)
      $display("FAIL async_reload: got secs=%0d sleeping=%b lvl=%0d expected 2 1 0",
               secs_left, sleeping, lock_level);
    else n_pass++;
    sleep = 0;
    step();
  endtask

  initial begin
    system_reset     = 0;
    sleep            = 0;
    correct_password = 0;
    model_reset();
    test_reset();
    test_first_lockout();
    test_escalation();
    test_clear();
    test_abort();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
